// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Package : motor_pkg
// Brief   : Direction codes, channel state encoding and bridge pin patterns.
// Rev     : 1.0
// ============================================================================
package motor_pkg;

    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_REV   = 2'b01;
    localparam logic [1:0] CMD_FWD   = 2'b10;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_RUN_F = 3'd1,
        ST_RUN_R = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } chan_state_e;

    // {in1, in2}
    localparam logic [1:0] PINS_OFF   = 2'b00;
    localparam logic [1:0] PINS_FWD   = 2'b10;
    localparam logic [1:0] PINS_REV   = 2'b01;
    localparam logic [1:0] PINS_BRAKE = 2'b11;

    function automatic chan_state_e cmd_to_state(input logic [1:0] cmd);
        case (cmd)
            CMD_FWD:   cmd_to_state = ST_RUN_F;
            CMD_REV:   cmd_to_state = ST_RUN_R;
            CMD_BRAKE: cmd_to_state = ST_BRAKE;
            default:   cmd_to_state = ST_COAST;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_channel_seq.sv
`default_nettype none
// ============================================================================
// Module : motor_channel_seq
// Brief  : One H-bridge channel: command filter, state machine with
//          dead-time, duty latch and registered pin outputs.
// Rev    : 1.0
// ============================================================================
module motor_channel_seq
    import motor_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STABLE_CYC = 1000,
    parameter int DEAD_CYC   = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_cmd,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_in1,
    output logic                o_in2,
    output logic                o_en,
    output logic                o_busy
);

    localparam int FW = $clog2(STABLE_CYC + 1);
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [FW-1:0] C_STABLE    = FW'(STABLE_CYC);
    localparam logic [DW-1:0] C_DEAD_LAST = DW'(DEAD_CYC - 1);

    logic [1:0]          prev_q, prev_d;
    logic [FW-1:0]       filt_cnt_q, filt_cnt_d;
    logic [1:0]          cmd_q, cmd_d;
    chan_state_e         state_q, state_d;
    logic [DW-1:0]       dead_cnt_q, dead_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [1:0]          pins_q, pins_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                w_pwm_on;

    // Filter: the first cycle of a new code counts as 1, acceptance at STABLE_CYC.
    always_comb begin
        prev_d     = i_cmd;
        filt_cnt_d = filt_cnt_q;
        cmd_d      = cmd_q;
        if (i_cmd != prev_q) begin
            filt_cnt_d = FW'(1);
        end else if (filt_cnt_q != C_STABLE) begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end
        if (filt_cnt_d == C_STABLE) begin
            cmd_d = i_cmd;
        end
    end

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            ST_COAST: begin
                state_d = cmd_to_state(cmd_q);
            end
            ST_RUN_F: begin
                if (cmd_q == CMD_REV) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end else begin
                    state_d = cmd_to_state(cmd_q);
                end
            end
            ST_RUN_R: begin
                if (cmd_q == CMD_FWD) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end else begin
                    state_d = cmd_to_state(cmd_q);
                end
            end
            ST_BRAKE: begin
                if (cmd_q == CMD_COAST) begin
                    state_d = ST_COAST;
                end else if (cmd_q != CMD_BRAKE) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end
            end
            ST_DEAD: begin
                // Fixed length; the command is only consulted on the last cycle.
                if (dead_cnt_q == C_DEAD_LAST) begin
                    state_d = cmd_to_state(cmd_q);
                end else begin
                    dead_cnt_d = dead_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_COAST;
            end
        endcase
    end

    // Duty is refreshed only at the start of a PWM period.
    always_comb begin
        duty_d   = (i_pwm_cnt == '0) ? i_duty : duty_q;
        w_pwm_on = (i_pwm_cnt < duty_d);
        pins_d   = PINS_OFF;
        en_d     = 1'b0;
        busy_d   = 1'b0;
        case (state_d)
            ST_RUN_F: begin
                pins_d = PINS_FWD;
                en_d   = w_pwm_on;
            end
            ST_RUN_R: begin
                pins_d = PINS_REV;
                en_d   = w_pwm_on;
            end
            ST_BRAKE: begin
                pins_d = PINS_BRAKE;
                en_d   = 1'b1;
            end
            ST_DEAD: begin
                busy_d = 1'b1;
            end
            default: begin
                pins_d = PINS_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= CMD_COAST;
            filt_cnt_q <= '0;
            cmd_q      <= CMD_COAST;
            state_q    <= ST_COAST;
            dead_cnt_q <= '0;
            duty_q     <= '0;
            pins_q     <= PINS_OFF;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            filt_cnt_q <= filt_cnt_d;
            cmd_q      <= cmd_d;
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            duty_q     <= duty_d;
            pins_q     <= pins_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
        end
    end

    assign o_in1  = pins_q[1];
    assign o_in2  = pins_q[0];
    assign o_en   = en_q;
    assign o_busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/motor_bridge_sequencer.sv
`default_nettype none
// ============================================================================
// Module : motor_bridge_sequencer
// Brief  : Two independent H-bridge channels sharing one PWM period counter.
// Rev    : 1.0
// ============================================================================
module motor_bridge_sequencer
    import motor_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STABLE_CYC = 1000,
    parameter int DEAD_CYC   = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          directie_driverA,
    input  logic [1:0]          directie_driverB,
    input  logic [PWM_BITS-1:0] duty_a,
    input  logic [PWM_BITS-1:0] duty_b,
    output logic                in1_a,
    output logic                in2_a,
    output logic                en_a,
    output logic                in1_b,
    output logic                in2_b,
    output logic                en_b,
    output logic                busy_a,
    output logic                busy_b
);

    // Period is 2^PWM_BITS-1 so that the maximum duty value means always on.
    localparam logic [PWM_BITS-1:0] C_PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == C_PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    motor_channel_seq #(
        .PWM_BITS   (PWM_BITS),
        .STABLE_CYC (STABLE_CYC),
        .DEAD_CYC   (DEAD_CYC)
    ) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .i_cmd     (directie_driverA),
        .i_duty    (duty_a),
        .i_pwm_cnt (pwm_cnt_q),
        .o_in1     (in1_a),
        .o_in2     (in2_a),
        .o_en      (en_a),
        .o_busy    (busy_a)
    );

    motor_channel_seq #(
        .PWM_BITS   (PWM_BITS),
        .STABLE_CYC (STABLE_CYC),
        .DEAD_CYC   (DEAD_CYC)
    ) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .i_cmd     (directie_driverB),
        .i_duty    (duty_b),
        .i_pwm_cnt (pwm_cnt_q),
        .o_in1     (in1_b),
        .o_in2     (in2_b),
        .o_en      (en_b),
        .o_busy    (busy_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_motor_bridge_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_motor_bridge_sequencer
// Brief  : Scenario tasks plus randomized traffic against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_motor_bridge_sequencer;

    localparam int S   = 4;
    localparam int D   = 10;
    localparam int PER = 15;

    localparam int M_COAST = 0;
    localparam int M_F     = 1;
    localparam int M_R     = 2;
    localparam int M_BRAKE = 3;
    localparam int M_DEAD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dir_a, dir_b;
    logic [3:0] duty_a, duty_b;
    logic       in1_a, in2_a, en_a, in1_b, in2_b, en_b, busy_a, busy_b;
    logic [7:0] act;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] m_last [2];
    logic [1:0] m_acc  [2];
    int         m_run  [2];
    int         m_st   [2];
    int         m_dead_left [2];
    int         m_lat  [2];
    bit         m_en   [2];
    int         m_ph;

    motor_bridge_sequencer #(
        .PWM_BITS   (4),
        .STABLE_CYC (S),
        .DEAD_CYC   (D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .directie_driverA (dir_a),
        .directie_driverB (dir_b),
        .duty_a           (duty_a),
        .duty_b           (duty_b),
        .in1_a            (in1_a),
        .in2_a            (in2_a),
        .en_a             (en_a),
        .in1_b            (in1_b),
        .in2_b            (in2_b),
        .en_b             (en_b),
        .busy_a           (busy_a),
        .busy_b           (busy_b)
    );

    always #5 clk = ~clk;

    assign act = {in1_a, in2_a, en_a, busy_a, in1_b, in2_b, en_b, busy_b};

    function automatic int code_state(input logic [1:0] code);
        case (code)
            2'b10:   return M_F;
            2'b01:   return M_R;
            2'b11:   return M_BRAKE;
            default: return M_COAST;
        endcase
    endfunction

    // Opposing drive, or leaving brake into a drive state, must pass through dead-time.
    function automatic bit needs_dead(input int from, input int to);
        return (from == M_F && to == M_R) || (from == M_R && to == M_F) ||
               (from == M_BRAKE && (to == M_F || to == M_R));
    endfunction

    function automatic logic [3:0] exp_ch(input int c);
        case (m_st[c])
            M_F:     return {3'b10_0 | {2'b00, m_en[c]}, 1'b0};
            M_R:     return {2'b01, m_en[c], 1'b0};
            M_BRAKE: return 4'b1110;
            M_DEAD:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [7:0] exp_all();
        return {exp_ch(0), exp_ch(1)};
    endfunction

    task automatic model_update();
        logic [1:0] raw;
        int         duty;
        int         tgt;
        bit         on;
        if (rst) begin
            m_ph = 0;
            for (int c = 0; c < 2; c++) begin
                m_last[c] = 2'b00; m_acc[c] = 2'b00; m_run[c] = 0;
                m_st[c] = M_COAST; m_dead_left[c] = 0; m_lat[c] = 0; m_en[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                raw  = (c == 0) ? dir_a : dir_b;
                duty = (c == 0) ? int'(duty_a) : int'(duty_b);
                if (m_ph == 0) m_lat[c] = duty;
                on  = (m_ph < m_lat[c]);
                tgt = code_state(m_acc[c]);
                if (m_st[c] == M_DEAD) begin
                    if (m_dead_left[c] == 1) m_st[c] = tgt;
                    else m_dead_left[c]--;
                end else if (tgt != m_st[c]) begin
                    if (needs_dead(m_st[c], tgt)) begin
                        m_st[c] = M_DEAD;
                        m_dead_left[c] = D;
                    end else begin
                        m_st[c] = tgt;
                    end
                end
                if (raw == m_last[c]) m_run[c]++;
                else m_run[c] = 1;
                m_last[c] = raw;
                if (m_run[c] >= S) m_acc[c] = raw;
                m_en[c] = (m_st[c] == M_F || m_st[c] == M_R) ? on : (m_st[c] == M_BRAKE);
            end
            m_ph = (m_ph + 1) % PER;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dir_a = 2'b10; dir_b = 2'b00; duty_a = 4'd7; duty_b = 4'd9;
        repeat (2) begin
            tick();
            n_cmp++;
            if (act !== 8'h00) begin
                n_fail++; $display("FAIL reset_outputs got=%b want=%b", act, 8'h00);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL reset_release cyc=%0d got=%b want=%b", i, act, exp_all());
            end
            if (i == 4) begin
                n_cmp++;
                if (in1_a !== 1'b0) begin
                    n_fail++; $display("FAIL reset_fwd_early got=%b want=0", in1_a);
                end
            end
        end
        n_cmp++;
        if (in1_a !== 1'b1 || in2_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_fwd_5th got in1=%b in2=%b want in1=1 in2=0", in1_a, in2_a);
        end
    endtask

    task automatic test_glitch();
        int len;
        dir_a = 2'b00;
        repeat (8) begin
            tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL glitch_settle got=%b want=%b", act, exp_all());
            end
        end
        for (int t = 0; t < 3; t++) begin
            len = $urandom_range(1, S - 1);
            dir_a = 2'b10;
            repeat (len) begin
                tick(); n_cmp++;
                if (act !== exp_all()) begin
                    n_fail++; $display("FAIL glitch_pulse got=%b want=%b", act, exp_all());
                end
            end
            dir_a = 2'b00;
            repeat (6) begin
                tick(); n_cmp++;
                if (act !== exp_all()) begin
                    n_fail++; $display("FAIL glitch_after got=%b want=%b", act, exp_all());
                end
            end
            n_cmp++;
            if (in1_a !== 1'b0 || en_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++; $display("FAIL glitch_ignored len=%0d got in1=%b en=%b want 0", len, in1_a, en_a);
            end
        end
        dir_a = 2'b10;
        repeat (S + 1) begin
            tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL glitch_hold got=%b want=%b", act, exp_all());
            end
        end
        n_cmp++;
        if (in1_a !== 1'b1 || in2_a !== 1'b0) begin
            n_fail++; $display("FAIL glitch_accept got in1=%b in2=%b want 1/0", in1_a, in2_a);
        end
    endtask

    task automatic test_reversal();
        int k, cnt;
        dir_a = 2'b01;
        k = 0;
        while (busy_a !== 1'b1 && k < 20) begin
            tick(); k++; n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL rev_wait got=%b want=%b", act, exp_all());
            end
        end
        n_cmp++;
        if (k != S + 1) begin
            n_fail++; $display("FAIL rev_latency got=%0d want=%0d", k, S + 1);
        end
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 30) begin
            cnt++; tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL rev_dead got=%b want=%b", act, exp_all());
            end
        end
        n_cmp++;
        if (cnt != D) begin
            n_fail++; $display("FAIL rev_dead_len got=%0d want=%0d", cnt, D);
        end
        n_cmp++;
        if (in1_a !== 1'b0 || in2_a !== 1'b1) begin
            n_fail++; $display("FAIL rev_run_r got in1=%b in2=%b want 0/1", in1_a, in2_a);
        end
    endtask

    task automatic test_brake();
        int cnt;
        bit seen_busy;
        dir_b = 2'b01;
        repeat (S + 2) begin
            tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL brake_run_r got=%b want=%b", act, exp_all());
            end
        end
        dir_b = 2'b11;
        seen_busy = 1'b0;
        repeat (S + 2) begin
            tick(); n_cmp++;
            if (busy_b === 1'b1) seen_busy = 1'b1;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL brake_enter got=%b want=%b", act, exp_all());
            end
        end
        n_cmp++;
        if ({in1_b, in2_b, en_b, busy_b} !== 4'b1110 || seen_busy) begin
            n_fail++; $display("FAIL brake_pins got=%b busy_seen=%0d want=1110 busy_seen=0",
                               {in1_b, in2_b, en_b, busy_b}, seen_busy);
        end
        dir_b = 2'b10;
        cnt = 0;
        while (busy_b !== 1'b1 && cnt < 20) begin
            tick(); cnt++; n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL brake_exit_wait got=%b want=%b", act, exp_all());
            end
        end
        cnt = 0;
        while (busy_b === 1'b1 && cnt < 30) begin
            cnt++; tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL brake_dead got=%b want=%b", act, exp_all());
            end
        end
        n_cmp++;
        if (cnt != D || in1_b !== 1'b1 || in2_b !== 1'b0) begin
            n_fail++; $display("FAIL brake_to_fwd dead=%0d in1=%b in2=%b want dead=%0d in1=1 in2=0",
                               cnt, in1_b, in2_b, D);
        end
    endtask

    task automatic test_pwm();
        int on;
        logic [3:0] duties [3];
        int         want   [3];
        duties[0] = 4'd5;  want[0] = 5;
        duties[1] = 4'd0;  want[1] = 0;
        duties[2] = 4'd15; want[2] = 15;
        dir_a = 2'b10;
        for (int d = 0; d < 3; d++) begin
            duty_a = duties[d];
            repeat ((d == 0) ? 40 : 30) begin
                tick(); n_cmp++;
                if (act !== exp_all()) begin
                    n_fail++; $display("FAIL pwm_settle duty=%0d got=%b want=%b", duties[d], act, exp_all());
                end
            end
            on = 0;
            repeat (PER) begin
                tick(); n_cmp++;
                on += int'(en_a === 1'b1);
                if (act !== exp_all()) begin
                    n_fail++; $display("FAIL pwm_period duty=%0d got=%b want=%b", duties[d], act, exp_all());
                end
            end
            n_cmp++;
            if (on != want[d]) begin
                n_fail++; $display("FAIL pwm_high_count duty=%0d got=%0d want=%0d", duties[d], on, want[d]);
            end
        end
    endtask

    task automatic test_reset_mid_dead();
        int  k;
        bit  seen_busy;
        duty_a = 4'd6;
        dir_a  = 2'b01;
        k = 0;
        while (busy_a !== 1'b1 && k < 20) begin
            tick(); k++; n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL rmd_wait got=%b want=%b", act, exp_all());
            end
        end
        repeat (5) begin
            tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL rmd_dead got=%b want=%b", act, exp_all());
            end
        end
        rst = 1'b1; dir_a = 2'b10;
        tick();
        n_cmp++;
        if (act !== 8'h00) begin
            n_fail++; $display("FAIL rmd_reset got=%b want=%b", act, 8'h00);
        end
        rst = 1'b0;
        seen_busy = 1'b0;
        repeat (S + 1) begin
            tick(); n_cmp++;
            if (busy_a === 1'b1) seen_busy = 1'b1;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL rmd_refwd got=%b want=%b", act, exp_all());
            end
        end
        n_cmp++;
        if (seen_busy || in1_a !== 1'b1) begin
            n_fail++; $display("FAIL rmd_no_dead busy_seen=%0d in1=%b want busy_seen=0 in1=1", seen_busy, in1_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 5) == 0) dir_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) dir_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) duty_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) duty_b = 4'($urandom_range(0, 15));
            tick(); n_cmp++;
            if (act !== exp_all()) begin
                n_fail++; $display("FAIL random cyc=%0d got=%b want=%b", i, act, exp_all());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_reversal();
        test_brake();
        test_pwm();
        test_reset_mid_dead();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
